jtag_scan_master: RTL and testbench
===================================

JTAG_SCAN_MASTER -- requirements
Module: jtag_scan_master

Interface
REQ-001 Parameter TCK_DIV, default 2: clk cycles per TCK half-period; legal range 1..255.
REQ-002 Parameter IR_WIDTH, default 2: instruction register length in bits.
REQ-003 Parameter DR_MAX, default 38: maximum data-register scan length in bits.
REQ-004 Port clk, in, 1: the block's single clock; all logic is on its rising edge.
REQ-005 Port reset, in, 1: synchronous, active-high reset.
REQ-006 Port cmd_valid, in, 1: a scan command is presented.
REQ-007 Port cmd_ready, out, 1: the block accepts the command on this cycle.
REQ-008 Port cmd_ir_en, in, 1: perform an IR scan before the DR scan.
REQ-009 Port cmd_ir, in, IR_WIDTH: IR value to shift in, LSB first.
REQ-010 Port cmd_dr_len, in, 6: DR scan length in bits; 0 skips the DR scan.
REQ-011 Port cmd_dr, in, DR_MAX: DR value to shift in, LSB first.
REQ-012 Port rsp_valid, out, 1: scan result is available.
REQ-013 Port rsp_ready, in, 1: the consumer accepts the result.
REQ-014 Port rsp_ir, out, IR_WIDTH: TDO bits captured during the IR scan.
REQ-015 Port rsp_dr, out, DR_MAX: TDO bits captured during the DR scan, right-aligned.
REQ-016 Ports tck, tms, tdi: outputs, 1 bit each, driving the TAP.
REQ-017 Port tdo, in, 1: TAP serial output.
REQ-018 Port busy, out, 1: high whenever the FSM is not in IDLE.

Function
REQ-019 Each TCK period SHALL last 2*TCK_DIV clk cycles: tck low for the first half, high for the second.
REQ-020 tms and tdi SHALL change only on the clk edge that starts a period, while tck falls or is low.
REQ-021 tdo SHALL be sampled on the clk edge where tck rises.
REQ-022 FSM states SHALL be TRST, IDLE, IR_PRE, IR_SHIFT, IR_POST, DR_PRE, DR_SHIFT, DR_POST and RESP.
REQ-023 TRST SHALL drive 5 periods with tms=1, then 1 period with tms=0, which parks the TAP in Run-Test/Idle; it then goes to IDLE.
REQ-024 In IDLE, cmd_ready SHALL be 1 and tck SHALL be held at 0; cmd_ready SHALL be 0 in every other state.
REQ-025 A command is accepted on a cycle with cmd_valid=1 and cmd_ready=1; all cmd_* fields are registered on that cycle.
REQ-026 After acceptance, the FSM SHALL go to IR_PRE if cmd_ir_en=1, to DR_PRE if cmd_dr_len!=0, and otherwise directly to RESP.
REQ-027 IR_PRE SHALL drive tms 1,1,0,0, one value per period, placing the TAP in Shift-IR.
REQ-028 IR_SHIFT SHALL run IR_WIDTH periods with tdi=cmd_ir[i]; tms=0 on every period except the last, which has tms=1.
REQ-029 IR_POST SHALL drive tms 1,0 (Update-IR, then Run-Test/Idle).
REQ-030 After IR_POST, the FSM SHALL go to DR_PRE if cmd_dr_len!=0, otherwise to RESP.
REQ-031 DR_PRE SHALL drive tms 1,0,0.
REQ-032 DR_SHIFT SHALL run L periods, L=min(cmd_dr_len, DR_MAX); the last period has tms=1.
REQ-033 DR_POST SHALL drive tms 1,0.
REQ-034 Bit i of TDO captured during IR_SHIFT SHALL go to rsp_ir[i].
REQ-035 Bit i of TDO captured during DR_SHIFT SHALL go to rsp_dr[i]; rsp_dr[DR_MAX-1:L] SHALL be 0.
REQ-036 When an IR or DR scan is skipped, its rsp field SHALL be 0.
REQ-037 In RESP, rsp_valid=1 with rsp_* held stable until rsp_ready=1; the FSM then returns to IDLE on the next cycle.
REQ-038 In all non-shift states tdi SHALL be 0.
REQ-039 A scan's total duration in TCK periods SHALL be (ir_en ? 6+IR_WIDTH : 0) + (L ? L+5 : 0).
REQ-040 A cmd_dr_len greater than DR_MAX SHALL be clamped to DR_MAX; this is not an error.

Reset
REQ-041 Reset SHALL take priority over all other inputs.
REQ-042 On reset, outputs SHALL be: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_ir=0, rsp_dr=0, busy=1; the FSM goes to TRST.
REQ-043 Reset asserted mid-scan SHALL abort the scan, drop any pending response, and rerun TRST.

Verification (TCK_DIV=2; bench TAP model with IR_WIDTH=2, DR capture value 38'h2A_DEAD_BEEF, IR capture value 2'b01)
REQ-044 Release reset -> 6 TCK periods with tms 1,1,1,1,1,0; cmd_ready rises 24 clk after reset deasserts.
REQ-045 Command ir_en=1, ir=2'b10, dr_len=38, dr=38'h15_1234_5678 -> 51 periods total; TAP IR=2'b10, TAP DR=38'h15_1234_5678; rsp_ir=2'b01, rsp_dr=38'h2A_DEAD_BEEF.
REQ-046 Command ir_en=0, dr_len=8, dr=38'hA5 -> 13 periods; rsp_dr=38'hEF; rsp_ir=0.
REQ-047 Command ir_en=0, dr_len=0 -> no tck edges; rsp_valid asserts within 2 clk; rsp_ready held low 10 clk -> rsp_valid and data stay stable and cmd_ready stays 0.
REQ-048 Command dr_len=50 -> clamped to 38-bit scan (43 periods); upper rsp bits are 0 only for lengths below 38.
REQ-049 Reset pulsed during DR_SHIFT bit 20 -> rsp_valid never asserts; the TRST sequence repeats; a subsequent command completes correctly.

Source files
------------

// File: rtl/jtag_scan_master.sv
// JTAG scan master: turns IR/DR scan commands into a TAP bit stream.
// tck runs at clk/(2*TCK_DIV); tdo is sampled when tck rises.
module jtag_scan_master #(
   parameter int TCK_DIV  = 2,
   parameter int IR_WIDTH = 2,
   parameter int DR_MAX   = 38
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_ir_en,
   input  logic [IR_WIDTH-1:0] cmd_ir,
   input  logic [5:0]          cmd_dr_len,
   input  logic [DR_MAX-1:0]   cmd_dr,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IR_WIDTH-1:0] rsp_ir,
   output logic [DR_MAX-1:0]   rsp_dr,
   output logic                tck,
   output logic                tms,
   output logic                tdi,
   input  logic                tdo,
   output logic                busy
);

   typedef enum logic [3:0] {
      TRST, IDLE, IR_PRE, IR_SHIFT, IR_POST,
      DR_PRE, DR_SHIFT, DR_POST, RESP
   } state_e;

   localparam int PH_W  = $clog2(2 * TCK_DIV);
   localparam int CNT_W = $clog2(DR_MAX + IR_WIDTH + 8) + 1;
   localparam logic [PH_W-1:0] PH_RISE = PH_W'(TCK_DIV - 1);
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * TCK_DIV - 1);

   state_e              state_q, nst_d, first_c;
   logic [PH_W-1:0]     ph_q;
   logic [CNT_W-1:0]    cnt_q, ncnt_d, len_q, len_c;
   logic                last_d, ntms_d;
   logic [IR_WIDTH-1:0] ir_sh_q, ir_mask_q, rsp_ir_q;
   logic [DR_MAX-1:0]   dr_sh_q, dr_mask_q, rsp_dr_q;
   logic                tck_q, tms_q, tdi_q;

   // tms value for period c of state s
   function automatic logic tms_of(state_e s, logic [CNT_W-1:0] c,
                                   logic [CNT_W-1:0] l);
      case (s)
         TRST:     return c < CNT_W'(5);
         IR_PRE:   return c < CNT_W'(2);
         IR_SHIFT: return c == CNT_W'(IR_WIDTH - 1);
         IR_POST,
         DR_PRE,
         DR_POST:  return c == '0;
         DR_SHIFT: return c == l - CNT_W'(1);
         default:  return 1'b0;
      endcase
   endfunction

   assign len_c = (int'(cmd_dr_len) > DR_MAX) ? CNT_W'(DR_MAX)
                                              : CNT_W'(cmd_dr_len);
   assign first_c = cmd_ir_en ? IR_PRE :
                    (len_c != '0) ? DR_PRE : RESP;

   // Where the scan goes at the end of the current TCK period
   always_comb begin
      nst_d  = state_q;
      last_d = 1'b0;
      case (state_q)
         TRST: begin
            last_d = cnt_q == CNT_W'(5);
            if (last_d) nst_d = IDLE;
         end
         IR_PRE: begin
            last_d = cnt_q == CNT_W'(3);
            if (last_d) nst_d = IR_SHIFT;
         end
         IR_SHIFT: begin
            last_d = cnt_q == CNT_W'(IR_WIDTH - 1);
            if (last_d) nst_d = IR_POST;
         end
         IR_POST: begin
            last_d = cnt_q == CNT_W'(1);
            if (last_d) nst_d = (len_q != '0) ? DR_PRE : RESP;
         end
         DR_PRE: begin
            last_d = cnt_q == CNT_W'(2);
            if (last_d) nst_d = DR_SHIFT;
         end
         DR_SHIFT: begin
            last_d = cnt_q == len_q - CNT_W'(1);
            if (last_d) nst_d = DR_POST;
         end
         DR_POST: begin
            last_d = cnt_q == CNT_W'(1);
            if (last_d) nst_d = RESP;
         end
         default: ;
      endcase
      ncnt_d = last_d ? '0 : cnt_q + CNT_W'(1);
      ntms_d = tms_of(nst_d, ncnt_d, len_q);
   end

   // Scan FSM: period timing, TAP pins, capture and handshakes
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= TRST;
         ph_q      <= '0;
         cnt_q     <= '0;
         len_q     <= '0;
         tck_q     <= 1'b0;
         tms_q     <= 1'b1;
         tdi_q     <= 1'b0;
         ir_sh_q   <= '0;
         dr_sh_q   <= '0;
         ir_mask_q <= '0;
         dr_mask_q <= '0;
         rsp_ir_q  <= '0;
         rsp_dr_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               tck_q <= 1'b0;
               tms_q <= 1'b0;
               tdi_q <= 1'b0;
               if (cmd_valid) begin
                  state_q   <= first_c;
                  ph_q      <= '0;
                  cnt_q     <= '0;
                  len_q     <= len_c;
                  tms_q     <= tms_of(first_c, '0, len_c);
                  ir_sh_q   <= cmd_ir;
                  dr_sh_q   <= cmd_dr;
                  ir_mask_q <= IR_WIDTH'(1);
                  dr_mask_q <= DR_MAX'(1);
                  rsp_ir_q  <= '0;
                  rsp_dr_q  <= '0;
               end
            end
            RESP: begin
               if (rsp_ready) state_q <= IDLE;
            end
            default: begin
               if (ph_q == PH_RISE) begin
                  tck_q <= 1'b1;
                  if (state_q == IR_SHIFT) begin
                     if (tdo) rsp_ir_q <= rsp_ir_q | ir_mask_q;
                     ir_mask_q <= ir_mask_q << 1;
                  end
                  if (state_q == DR_SHIFT) begin
                     if (tdo) rsp_dr_q <= rsp_dr_q | dr_mask_q;
                     dr_mask_q <= dr_mask_q << 1;
                  end
               end
               if (ph_q == PH_LAST) begin
                  ph_q    <= '0;
                  tck_q   <= 1'b0;
                  cnt_q   <= ncnt_d;
                  state_q <= nst_d;
                  tms_q   <= ntms_d;
                  tdi_q   <= 1'b0;
                  if (nst_d == IR_SHIFT) begin
                     tdi_q   <= ir_sh_q[0];
                     ir_sh_q <= ir_sh_q >> 1;
                  end
                  if (nst_d == DR_SHIFT) begin
                     tdi_q   <= dr_sh_q[0];
                     dr_sh_q <= dr_sh_q >> 1;
                  end
               end else begin
                  ph_q <= ph_q + PH_W'(1);
               end
            end
         endcase
      end
   end

   assign cmd_ready = state_q == IDLE;
   assign rsp_valid = state_q == RESP;
   assign busy      = state_q != IDLE;
   assign rsp_ir    = rsp_ir_q;
   assign rsp_dr    = rsp_dr_q;
   assign tck       = tck_q;
   assign tms       = tms_q;
   assign tdi       = tdi_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: behavioural TAP with 2-bit IR and
// 38-bit DR, directed scans with hand-computed results.
module tb_jtag_scan_master;

   localparam logic [37:0] CAP_DR = 38'h2A_DEAD_BEEF;
   localparam logic [1:0]  CAP_IR = 2'b01;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_ir_en = 1'b0;
   logic [1:0]  cmd_ir = '0;
   logic [5:0]  cmd_dr_len = '0;
   logic [37:0] cmd_dr = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [1:0]  rsp_ir;
   logic [37:0] rsp_dr;
   logic        tck, tms, tdi, busy;
   logic        tdo_m = 1'b0;

   int checks = 0;
   int failures = 0;

   jtag_scan_master #(
      .TCK_DIV(2), .IR_WIDTH(2), .DR_MAX(38)
   ) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_ir_en(cmd_ir_en), .cmd_ir(cmd_ir),
      .cmd_dr_len(cmd_dr_len), .cmd_dr(cmd_dr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_ir(rsp_ir), .rsp_dr(rsp_dr),
      .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo_m),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // TAP model
   typedef enum logic [3:0] {
      TLR, RTI, SDS, CDR, SHDR, E1DR, PDR, E2DR, UDR,
      SIS, CIR, SHIR, E1IR, PIR, E2IR, UIR
   } tap_e;

   tap_e        tap_st = TLR;
   logic [37:0] dsh = '0, dreg = '0;
   logic [1:0]  ish = '0, ireg = '0;
   logic [63:0] tms_log = '0;
   int          tck_cnt = 0;

   function automatic tap_e tap_next(tap_e s, logic m);
      case (s)
         TLR:  return m ? TLR  : RTI;
         RTI:  return m ? SDS  : RTI;
         SDS:  return m ? SIS  : CDR;
         CDR:  return m ? E1DR : SHDR;
         SHDR: return m ? E1DR : SHDR;
         E1DR: return m ? UDR  : PDR;
         PDR:  return m ? E2DR : PDR;
         E2DR: return m ? UDR  : SHDR;
         UDR:  return m ? SDS  : RTI;
         SIS:  return m ? TLR  : CIR;
         CIR:  return m ? E1IR : SHIR;
         SHIR: return m ? E1IR : SHIR;
         E1IR: return m ? UIR  : PIR;
         PIR:  return m ? E2IR : PIR;
         E2IR: return m ? UIR  : SHIR;
         default: return m ? SDS : RTI;
      endcase
   endfunction

   always @(posedge tck) begin
      case (tap_st)
         CDR:  dsh  <= CAP_DR;
         SHDR: dsh  <= {tdi, dsh[37:1]};
         UDR:  dreg <= dsh;
         CIR:  ish  <= CAP_IR;
         SHIR: ish  <= {tdi, ish[1]};
         UIR:  ireg <= ish;
         default: ;
      endcase
      tap_st  <= tap_next(tap_st, tms);
      tms_log <= {tms_log[62:0], tms};
      tck_cnt <= tck_cnt + 1;
   end

   always @(negedge tck) begin
      tdo_m <= (tap_st == SHDR) ? dsh[0] :
               (tap_st == SHIR) ? ish[0] : 1'b0;
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive one command and wait (bounded) for rsp_valid
   task automatic run_cmd(input logic ie, input logic [1:0] ir,
                          input logic [5:0] len,
                          input logic [37:0] dr,
                          output int per, output int lat,
                          output logic tmo);
      int p0;
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_ir_en  = ie;
      cmd_ir     = ir;
      cmd_dr_len = len;
      cmd_dr     = dr;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      p0  = tck_cnt;
      lat = 1;
      tmo = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (rsp_valid) begin
            tmo = 1'b0;
            break;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      per = tck_cnt - p0;
   endtask

   task automatic ack_rsp(input string tag);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk(tag, 64'(cmd_ready), 64'd1);
   endtask

   // Release reset and count clk edges until cmd_ready
   task automatic trst_seq(input string tag, output int n,
                           output logic seen);
      int p0;
      @(negedge clk);
      reset = 1'b0;
      p0   = tck_cnt;
      n    = 0;
      seen = 1'b0;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk);
         #1;
         seen = seen | rsp_valid;
         if (cmd_ready) begin
            n = i;
            break;
         end
      end
      chk({tag, "_lat"}, 64'(n), 64'd24);
      chk({tag, "_per"}, 64'(tck_cnt - p0), 64'd6);
      chk({tag, "_tms"}, 64'(tms_log[5:0]), 64'h3E);
      chk({tag, "_tap"}, 64'(tap_st), 64'(RTI));
   endtask

   initial begin
      int          per, lat, n, p0;
      logic        tmo, seen;
      logic [37:0] d0;
      logic [1:0]  i0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tck", 64'(tck), 64'd0);
      chk("rst_tms", 64'(tms), 64'd1);
      chk("rst_tdi", 64'(tdi), 64'd0);
      chk("rst_rdy", 64'(cmd_ready), 64'd0);
      chk("rst_rv", 64'(rsp_valid), 64'd0);
      chk("rst_rsp", 64'({rsp_ir, rsp_dr}), 64'd0);
      chk("rst_busy", 64'(busy), 64'd1);

      trst_seq("trst", n, seen);
      chk("idle_busy", 64'(busy), 64'd0);

      // IR + full DR scan
      run_cmd(1'b1, 2'b10, 6'd38, 38'h15_1234_5678, per, lat, tmo);
      chk("s1_tmo", 64'(tmo), 64'd0);
      chk("s1_per", 64'(per), 64'd51);
      chk("s1_tapir", 64'(ireg), 64'h2);
      chk("s1_tapdr", 64'(dreg), 64'h15_1234_5678);
      chk("s1_rir", 64'(rsp_ir), 64'h1);
      chk("s1_rdr", 64'(rsp_dr), 64'h2A_DEAD_BEEF);
      chk("s1_tap", 64'(tap_st), 64'(RTI));
      ack_rsp("s1_ack");

      // DR-only 8-bit scan
      run_cmd(1'b0, 2'b00, 6'd8, 38'hA5, per, lat, tmo);
      chk("s2_tmo", 64'(tmo), 64'd0);
      chk("s2_per", 64'(per), 64'd13);
      chk("s2_tms", 64'(tms_log[12:0]), 64'h1006);
      chk("s2_rdr", 64'(rsp_dr), 64'hEF);
      chk("s2_rir", 64'(rsp_ir), 64'h0);
      chk("s2_tapdr", 64'(dreg), 64'h29_6ADE_ADBE);
      ack_rsp("s2_ack");

      // Empty command, consumer stalls
      p0 = tck_cnt;
      run_cmd(1'b0, 2'b11, 6'd0, 38'h3F_0000_0001, per, lat, tmo);
      chk("s3_tmo", 64'(tmo), 64'd0);
      chk("s3_lat", 64'(lat <= 2), 64'd1);
      d0 = rsp_dr;
      i0 = rsp_ir;
      chk("s3_rsp", 64'({i0, d0}), 64'd0);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (!rsp_valid || cmd_ready || rsp_dr !== d0 || rsp_ir !== i0)
            seen = 1'b1;
      end
      chk("s3_stall", 64'(seen), 64'd0);
      chk("s3_notck", 64'(tck_cnt - p0), 64'd0);
      ack_rsp("s3_ack");

      // Over-long length clamps to 38
      run_cmd(1'b0, 2'b00, 6'd50, 38'h00_0000_0001, per, lat, tmo);
      chk("s4_tmo", 64'(tmo), 64'd0);
      chk("s4_per", 64'(per), 64'd43);
      chk("s4_rdr", 64'(rsp_dr), 64'h2A_DEAD_BEEF);
      chk("s4_tapdr", 64'(dreg), 64'h1);
      ack_rsp("s4_ack");

      // 37 bits: top rsp bit must be zero
      run_cmd(1'b0, 2'b00, 6'd37, 38'h0, per, lat, tmo);
      chk("s5_per", 64'(per), 64'd42);
      chk("s5_rdr", 64'(rsp_dr), 64'h0A_DEAD_BEEF);
      ack_rsp("s5_ack");

      // Reset during DR_SHIFT bit 20
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_ir_en  = 1'b0;
      cmd_dr_len = 6'd38;
      cmd_dr     = 38'h3F_FFFF_FFFF;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      p0  = tck_cnt;
      tmo = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         if (tck_cnt - p0 >= 24) begin
            tmo = 1'b0;
            break;
         end
         @(posedge clk);
         #1;
      end
      chk("ab_tmo", 64'(tmo), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("ab_busy", 64'(busy), 64'd1);
      chk("ab_tms", 64'(tms), 64'd1);
      chk("ab_tck", 64'(tck), 64'd0);
      chk("ab_rv", 64'(rsp_valid), 64'd0);
      trst_seq("ab", n, seen);
      chk("ab_norsp", 64'(seen), 64'd0);

      run_cmd(1'b0, 2'b00, 6'd8, 38'hA5, per, lat, tmo);
      chk("s6_tmo", 64'(tmo), 64'd0);
      chk("s6_per", 64'(per), 64'd13);
      chk("s6_rdr", 64'(rsp_dr), 64'hEF);
      ack_rsp("s6_ack");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
